// File: rtl/nn_ctrl_pkg.sv
// Shared control definitions for the NN datapath sequencers.
// Holds the layer FSM state encoding and default network geometry.
package nn_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam int QUADRANTS_DEF  = 4;
   localparam int NUM_LAYERS_DEF = 3;

endpackage

// File: rtl/layer_sequencer_if.sv
// Handshake/control bundle between host, memory manager, MAC array,
// writeback and the layer sequencer. slave = sequencer side.
interface layer_sequencer_if #(
   parameter int LAYER_W = 2
);

   logic               start;
   logic               abort;
   logic               stall;
   logic               vector_restarting;
   logic               a_element_ready;
   logic               writeback_ready;
   logic               imm_en;
   logic               imm_clear;
   logic               mac_clear;
   logic               mac_accumulate;
   logic               writeback_valid;
   logic [LAYER_W-1:0] layer_index;
   logic               busy;
   logic               done;
   logic               protocol_error;

   modport master (
      output start, abort, stall,
      output vector_restarting,
      output a_element_ready,
      output writeback_ready,
      input  imm_en, imm_clear,
      input  mac_clear, mac_accumulate,
      input  writeback_valid, layer_index,
      input  busy, done, protocol_error
   );

   modport slave (
      input  start, abort, stall,
      input  vector_restarting,
      input  a_element_ready,
      input  writeback_ready,
      output imm_en, imm_clear,
      output mac_clear, mac_accumulate,
      output writeback_valid, layer_index,
      output busy, done, protocol_error
   );

endinterface

// File: rtl/sequencer_counter.sv
// Loadable up-counter with terminal-count flag (tc = count==TERMINAL).
// Ports: clock, clear_n, load (sync zero), inc, tc.
module sequencer_counter #(
   parameter int W        = 3,
   parameter int TERMINAL = 3
) (
   input  logic clock,
   input  logic clear_n,
   input  logic load,
   input  logic inc,
   output logic tc
);

   logic [W-1:0] count;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == W'(TERMINAL));

endmodule

// File: rtl/layer_sequencer.sv
// Runs the memory-manager/MAC datapath through NUM_LAYERS layers.
// Ports: clock, clear_n (async, active-low), bus (slave modport).
module layer_sequencer
   import nn_ctrl_pkg::*;
#(
   parameter int NUM_LAYERS   = NUM_LAYERS_DEF,
   parameter int QUADRANTS    = QUADRANTS_DEF,
   parameter int DRAIN_CYCLES = 3,
   parameter int LAYER_W      = 2
) (
   input  logic               clock,
   input  logic               clear_n,
   layer_sequencer_if.slave   bus
);

   localparam int QW = $clog2(QUADRANTS) + 1;
   localparam int DW = $clog2(DRAIN_CYCLES) + 1;

   state_t             state_q;
   state_t             state_d;
   logic [LAYER_W-1:0] layer_q;
   logic               err_q;
   logic               quad_tc;
   logic               drain_tc;
   logic               last_layer;
   logic               bad_pulse;

   assign last_layer =
      (layer_q == LAYER_W'(NUM_LAYERS - 1));

   // Counting only happens in STREAM, so stray
   // pulses elsewhere never touch the count.
   sequencer_counter #(
      .W        (QW),
      .TERMINAL (QUADRANTS - 1)
   ) u_quad (
      .clock   (clock),
      .clear_n (clear_n),
      .load    ((state_q == CLEAR) | bus.abort),
      .inc     ((state_q == STREAM) &
                bus.vector_restarting &
                !bus.abort),
      .tc      (quad_tc)
   );

   // Held at zero outside DRAIN so each DRAIN
   // visit starts from a fresh count.
   sequencer_counter #(
      .W        (DW),
      .TERMINAL (DRAIN_CYCLES - 1)
   ) u_drain (
      .clock   (clock),
      .clear_n (clear_n),
      .load    ((state_q != DRAIN) | bus.abort),
      .inc     (state_q == DRAIN),
      .tc      (drain_tc)
   );

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:   if (bus.start) state_d = CLEAR;
            CLEAR:  state_d = STREAM;
            STREAM: begin
               if (bus.vector_restarting && quad_tc)
                  state_d = DRAIN;
            end
            DRAIN:  if (drain_tc) state_d = WRITE;
            WRITE: begin
               if (bus.writeback_ready)
                  state_d = last_layer ? DONE : CLEAR;
            end
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         layer_q <= '0;
      end else if (bus.abort || state_q == DONE) begin
         layer_q <= '0;
      end else if (state_q == WRITE &&
                   bus.writeback_ready &&
                   !last_layer) begin
         layer_q <= layer_q + 1'b1;
      end
   end

   assign bad_pulse =
      (bus.vector_restarting &&
       (state_q == IDLE || state_q == CLEAR ||
        state_q == WRITE)) ||
      (bus.a_element_ready &&
       (state_q == IDLE || state_q == WRITE));

   // A fresh violation in the start cycle wins
   // over the clear; abort freezes the flag.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         err_q <= 1'b0;
      end else if (!bus.abort) begin
         if (bad_pulse) begin
            err_q <= 1'b1;
         end else if (state_q == IDLE && bus.start) begin
            err_q <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.imm_clear       = (state_q == CLEAR);
      bus.mac_clear       = (state_q == CLEAR);
      bus.imm_en          = (state_q == STREAM) &&
                            !bus.stall;
      // DRAIN included: manager elements lag by 2 cycles.
      bus.mac_accumulate  = bus.a_element_ready &&
                            (state_q == STREAM ||
                             state_q == DRAIN);
      bus.writeback_valid = (state_q == WRITE);
      bus.done            = (state_q == DONE);
      bus.busy            = (state_q != IDLE);
      bus.layer_index     = layer_q;
      bus.protocol_error  = err_q;
   end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Top-level controller that runs the input_memory_manager / MAC datapath through a whole network, one layer at a time.
- Per layer: clears the manager and the accumulators, streams all weight quadrants, waits for the pipeline to drain, then handshakes the layer result out to the writeback stage.
- Sits between the host start/abort interface and the input memory manager, the MAC array and the writeback stage.

Parameters:
- NUM_LAYERS, 3: layers per inference; layer_index runs 0..NUM_LAYERS-1.
- QUADRANTS, 4: vector_restarting pulses that end one layer's stream.
- DRAIN_CYCLES, 3: idle cycles after the last quadrant before writeback; must be >= 1.
- LAYER_W, 2: width of layer_index; must satisfy 2^LAYER_W >= NUM_LAYERS.

Ports:
- clock, in, 1: single clock, rising edge.
- clear_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin inference; sampled only in IDLE.
- abort, in, 1: synchronous abort; highest priority after reset.
- stall, in, 1: backpressure; holds off streaming.
- vector_restarting, in, 1: quadrant-finished pulse from the input memory manager.
- a_element_ready, in, 1: element-valid from the input memory manager.
- writeback_ready, in, 1: writeback stage accepts the layer result.
- imm_en, out, 1: enable to the input memory manager.
- imm_clear, out, 1: clear to the input memory manager.
- mac_clear, out, 1: clear to the MAC accumulators.
- mac_accumulate, out, 1: accumulate strobe to the MAC array.
- writeback_valid, out, 1: layer result valid.
- layer_index, out, LAYER_W: current layer.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle inference-complete pulse.
- protocol_error, out, 1: sticky error flag.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE; layer_index=0; quadrant_count=0; drain_count=0; protocol_error=0.
  - All 1-bit outputs are 0.
- State transitions (abort=1 in any state forces IDLE on the next edge and sets layer_index=0; protocol_error is held):
  - IDLE: start=1 -> CLEAR and protocol_error<=0. start is ignored in every other state.
  - CLEAR: exactly one cycle. quadrant_count<=0 -> STREAM.
  - STREAM: each cycle with vector_restarting=1 increments quadrant_count. A pulse while quadrant_count==QUADRANTS-1 -> DRAIN with drain_count<=0. stall does not block counting.
  - DRAIN: drain_count increments every cycle. When drain_count==DRAIN_CYCLES-1 -> WRITE. Total DRAIN dwell is exactly DRAIN_CYCLES cycles.
  - WRITE: stays until writeback_ready=1 (handshake). Then, if layer_index==NUM_LAYERS-1 -> DONE; otherwise layer_index++ and -> CLEAR.
  - DONE: one cycle -> IDLE. layer_index<=0 on exit.
- Outputs are decoded combinationally from the state register and inputs:
  - imm_clear = mac_clear = (state==CLEAR).
  - imm_en = (state==STREAM) && !stall.
  - mac_accumulate = a_element_ready && (state==STREAM || state==DRAIN). This covers the manager's 2-cycle element latency crossing into DRAIN.
  - writeback_valid = (state==WRITE).
  - done = (state==DONE).
  - busy = (state!=IDLE).
- Latencies:
  - start to first imm_en: 2 cycles (IDLE->CLEAR->STREAM).
  - Last vector_restarting to writeback_valid: DRAIN_CYCLES+1 cycles.
- protocol_error is set, and held until the next accepted start, on either of:
  - vector_restarting=1 while state is IDLE, CLEAR or WRITE;
  - a_element_ready=1 while state is IDLE or WRITE.
  Offending pulses never alter the counters.
- Boundary conditions:
  - writeback_valid stays high while writeback_ready=0, indefinitely, with no timeout.
  - start and abort high in the same IDLE cycle: abort wins, state stays IDLE.
  - stall in STREAM only drops imm_en. State and counters hold unless vector_restarting arrives.
  - Reset or abort mid-layer leaves no partial counts: the next start begins at layer 0, quadrant 0.

Decomposition:
- Shared package nn_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, STREAM, DRAIN, WRITE, DONE);
  - the defaults for QUADRANTS and NUM_LAYERS, shared with input_memory_manager users.
- One natural sub-module: sequencer_counter, a loadable up-counter with terminal-count output, instantiated for the quadrant count and the drain count.
- FSM and output decode stay in layer_sequencer.

Test Plan:
1. Normal run, defaults: start pulse; 4 vector_restarting pulses spaced 64 cycles per layer; writeback_ready tied 1. Expect:
   - 3 CLEAR cycles with imm_clear=mac_clear=1;
   - writeback_valid 4 cycles after each 4th pulse;
   - layer_index 0->1->2;
   - done high 1 cycle; busy low the cycle after.
2. Writeback backpressure: hold writeback_ready=0 for 10 cycles in WRITE of layer 0. Expect:
   - writeback_valid high for all 10 cycles;
   - layer_index=0 until writeback_ready=1;
   - CLEAR on the next cycle.
3. Stall: assert stall for 5 cycles mid-STREAM. Expect imm_en=0 for exactly those 5 cycles and state stays STREAM. Then a vector_restarting pulse during the stall still increments quadrant_count; verify by DRAIN entry after 3 further pulses.
4. Abort mid-layer: abort in DRAIN of layer 1. Expect:
   - IDLE next cycle; layer_index=0; busy=0;
   - a new start runs layer 0 with quadrant_count restarted at 0.
5. Protocol error: vector_restarting while in IDLE. Expect protocol_error=1 and held; no state change. Next start clears it to 0 in the cycle after.
6. Async reset: drop clear_n in STREAM between clock edges. Expect all outputs 0 immediately, without waiting for a clock edge, and state IDLE after release.
